ps2_rx_fifo: RTL and testbench
==============================

# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver with deglitched clock, full 11-bit frame checking, inactivity timeout and an output FIFO with valid/ready handshake. It sits between the PS/2 pins and the keyboard scan-code decoder, replacing the single-byte, unbuffered receiver so that multi-byte scan codes (E0/F0 prefixes) are never lost while the decoder is busy.

## Interface
- FILTER_LEN, 8: length of the ps2c deglitch shift register, ≥2.
- FIFO_DEPTH, 8: number of buffered bytes, power of two, ≥2.
- TIMEOUT_CYCLES, 100000: clk cycles without a filtered ps2c falling edge before an in-progress frame is aborted. Default is 2 ms at 50 MHz.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- ps2d  in  1  PS/2 data line.
- ps2c  in  1  PS/2 clock line.
- rx_en  in  1  permits detection of a new start bit.
- rd_valid  out  1  FIFO non-empty; rd_data holds the head byte.
- rd_data  out  8  head byte, LSB-first as received.
- rd_ready  in  1  consumer accepts the head byte when rd_valid & rd_ready.
- count  out  $clog2(FIFO_DEPTH)+1  bytes held.
- busy  out  1  frame in progress (state ≠ IDLE).
- err_tick  out  1  one-cycle pulse: frame rejected by the parity or stop-bit check.
- overflow_tick  out  1  one-cycle pulse: good frame dropped because the FIFO is full.
- timeout_tick  out  1  one-cycle pulse: frame aborted on inactivity.

## Operation
- **Clock filter.** ps2c is right-shifted into a FILTER_LEN register each clk.
  - The filtered value becomes 1 when the register is all ones, 0 when it is all zeros, otherwise it holds.
  - fall = filtered value currently 1 and next value 0.
  - ps2d is sampled raw in the fall cycle.
- **FSM states: IDLE, RX, CHECK.**
  - IDLE: on fall & rx_en & ps2d==0, load the bit counter with 10, clear the timer and go to RX. A fall with ps2d==1 is ignored.
  - RX: each fall right-shifts ps2d into a 10-bit shift register (8 data, parity, stop), decrements the counter and clears the timer.
    - When the counter reaches 0, go to CHECK.
    - If the timer reaches TIMEOUT_CYCLES-1, pulse timeout_tick, discard the frame and go to IDLE.
    - rx_en low mid-frame does not abort.
  - CHECK (one cycle): the frame is good if parity is odd over data+parity and stop==1 (see Configuration).
    - Good & FIFO not full (after any same-cycle pop): push.
    - Good & full: overflow_tick.
    - Bad: err_tick.
    - Then go to IDLE.
- **FIFO.** Circular buffer with wrap-around read/write pointers; count = writes − reads.
  - Push and pop in the same cycle are both honoured and count is unchanged.
  - Pop when empty is ignored.
  - Push when full is allowed only if a pop happens in the same cycle.
- **Reset.** Asynchronous reset at any point, including mid-frame, empties the FIFO, sets state to IDLE and clears the filter register, filtered value (0), counter, timer and shift register.
- **Reset values.** rd_valid=0, rd_data=0, count=0, busy=0, all ticks 0.

## Timing
- The filtered edge lags the ps2c pin edge by FILTER_LEN+1 clk cycles.
- Let T be the cycle of the stop-bit fall. CHECK is at T+1. The pushed byte is visible at T+2: rd_valid=1, rd_data valid, count incremented. Latency from the stop-bit fall is 2 cycles.
- err_tick, overflow_tick and timeout_tick are asserted for exactly one cycle and are registered outputs.
- A pop at cycle P advances rd_data and count at P+1.
- rd_data is stable while rd_valid & !rd_ready.
- busy is high from the cycle after the start fall through CHECK inclusive.

## Configuration
- PS2_RX_PARITY_CHECK_EN defined: the CHECK state verifies odd parity and stop==1. Failing frames are dropped with err_tick.
- Not defined: every completed frame is treated as good. err_tick is tied to 0. The parity and stop bits are still shifted in but ignored.

## Test plan
- Send frame for 0x1C (parity=0, stop=1), FIFO empty, rd_ready=0 -> rd_valid=1, rd_data=0x1C, count=1 at T+2, no ticks.
- Send E0, F0, 1C back-to-back with rd_ready=0, then hold rd_ready=1 -> reads return E0, F0, 1C in order; count goes 3→0; rd_valid drops after the third pop.
- FIFO_DEPTH=8: send 9 frames with rd_ready=0 -> count=8, exactly one overflow_tick on the 9th frame, data 0–7 intact. Repeat with rd_ready=1 in that frame's CHECK cycle -> push accepted, count stays 8.
- With PS2_RX_PARITY_CHECK_EN: send 0x1C with parity=1 -> err_tick one cycle, count unchanged. Send a good frame with stop=0 -> err_tick. Without the macro: both frames pushed.
- Stop ps2c after 5 bits -> timeout_tick exactly TIMEOUT_CYCLES cycles after the last fall, busy=0. The next full frame is received correctly.
- Assert reset mid-frame with 3 bytes buffered -> all outputs zero and count=0 immediately. After release, a new frame gives count=1. A start fall with rx_en=0 -> busy stays 0.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: deglitched clock, 11-bit frame check, inactivity timeout, output FIFO.
// Optional parity/stop verification is enabled by defining PS2_RX_PARITY_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for a start-bit fall (needs rx_en and ps2d low)
// RX    | shifting data, parity and stop bits; inactivity timer running
// CHECK | one cycle: validate the frame, push to the FIFO or flag it
module ps2_rx_fifo #(
   parameter int FILTER_LEN     = 8,
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          ps2d,
   input  logic                          ps2c,
   input  logic                          rx_en,
   output logic                          rd_valid,
   output logic [7:0]                    rd_data,
   input  logic                          rd_ready,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          busy,
   output logic                          err_tick,
   output logic                          overflow_tick,
   output logic                          timeout_tick
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, RX, CHECK} state_t;

   state_t state, state_next;

   logic [FILTER_LEN-1:0] filt_sr;
   logic                  filt, filt_next, fall;
   logic [3:0]            bit_cnt;
   logic [TW-1:0]         timer;
   logic [9:0]            shift;
   logic                  load_start, shift_en, timeout_set, check;
   logic                  frame_good, full, pop, push;
   logic [AW:0]           wr_ptr, rd_ptr;
   logic [7:0]            mem [FIFO_DEPTH];

   // Clock deglitch: the filtered level only moves on a unanimous register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filt_sr <= '0;
         filt    <= 1'b0;
      end else begin
         filt_sr <= {ps2c, filt_sr[FILTER_LEN-1:1]};
         filt    <= filt_next;
      end
   end

   always_comb begin
      filt_next = filt;
      if (&filt_sr)
         filt_next = 1'b1;
      else if (~|filt_sr)
         filt_next = 1'b0;
   end

   assign fall = filt & ~filt_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Abort when the timer is about to reach its limit, so the tick lands
   // exactly TIMEOUT_CYCLES cycles after the last fall.
   always_comb begin
      state_next  = state;
      load_start  = 1'b0;
      shift_en    = 1'b0;
      timeout_set = 1'b0;
      check       = 1'b0;
      unique case (state)
         IDLE: begin
            if (fall && rx_en && !ps2d) begin
               load_start = 1'b1;
               state_next = RX;
            end
         end
         RX: begin
            if (fall) begin
               shift_en = 1'b1;
               if (bit_cnt == 4'd1)
                  state_next = CHECK;
            end else if (timer == TW'(TIMEOUT_CYCLES - 2)) begin
               timeout_set = 1'b1;
               state_next  = IDLE;
            end
         end
         CHECK: begin
            check      = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt <= '0;
         timer   <= '0;
         shift   <= '0;
      end else if (load_start) begin
         bit_cnt <= 4'd10;
         timer   <= '0;
      end else if (shift_en) begin
         shift   <= {ps2d, shift[9:1]};
         bit_cnt <= bit_cnt - 4'd1;
         timer   <= '0;
      end else if (state == RX) begin
         timer   <= timer + TW'(1);
      end
   end

`ifdef PS2_RX_PARITY_CHECK_EN
   assign frame_good = (^shift[8:0]) & shift[9];
`else
   // Parity and stop bits are still captured but play no part in acceptance.
   logic unused_frame_bits;
   assign unused_frame_bits = ^shift[9:8];
   assign frame_good        = 1'b1;
`endif

   assign count    = wr_ptr - rd_ptr;
   assign full     = (count == (AW+1)'(FIFO_DEPTH));
   assign rd_valid = (count != '0);
   assign pop      = rd_valid & rd_ready;
   assign push     = check & frame_good & (~full | pop);
   assign busy     = (state != IDLE);
   assign rd_data  = rd_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= shift[7:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         err_tick      <= 1'b0;
         overflow_tick <= 1'b0;
         timeout_tick  <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)
            rd_ptr <= rd_ptr + (AW+1)'(1);
         err_tick      <= check & ~frame_good;
         overflow_tick <= check & frame_good & full & ~pop;
         timeout_tick  <= timeout_set;
      end
   end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: bit-banged PS/2 frames, scoreboard of expected FIFO bytes.
// Expectations follow PS2_RX_PARITY_CHECK_EN when the bench is built with it.
module tb_ps2_rx_fifo;

   localparam int L  = 4;
   localparam int D  = 8;
   localparam int TO = 200;

   logic       clk = 1'b0;
   logic       reset, ps2d, ps2c, rx_en, rd_ready;
   logic       rd_valid, busy, err_tick, overflow_tick, timeout_tick;
   logic [7:0] rd_data;
   logic [$clog2(D):0] count;

   int checks = 0;
   int errors = 0;
   int n_err = 0, n_ovf = 0, n_to = 0, n_busy = 0;
   logic [7:0] sb [$];

   ps2_rx_fifo #(.FILTER_LEN(L), .FIFO_DEPTH(D), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .rx_en(rx_en),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready), .count(count),
      .busy(busy), .err_tick(err_tick), .overflow_tick(overflow_tick),
      .timeout_tick(timeout_tick)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (err_tick)      n_err++;
      if (overflow_tick) n_ovf++;
      if (timeout_tick)  n_to++;
      if (busy)          n_busy++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, expected finish before 2ms");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk); ps2d = b;
      repeat (5) @(negedge clk);
      ps2c = 1'b0;
      repeat (10) @(negedge clk);
      ps2c = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   // mode 0: plain; 1: check push latency on an empty FIFO; 2: pop during CHECK on a full FIFO
   task automatic send_frame(input logic [7:0] data, input logic par_flip, input logic stop,
                             input int mode);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(data[i]);
      send_bit(~^data ^ par_flip);
      @(negedge clk); ps2d = stop;
      repeat (5) @(negedge clk);
      ps2c = 1'b0;
      if (mode == 1) begin
         repeat (L+1) @(posedge clk);
         #1;
         check("lat_check_valid", rd_valid, 0);
         check("lat_check_busy", busy, 1);
         @(posedge clk);
         #1;
         check("lat_push_valid", rd_valid, 1);
         check("lat_push_data", rd_data, data);
         check("lat_push_count", count, 1);
         check("lat_push_busy", busy, 0);
         repeat (8) @(negedge clk);
      end else if (mode == 2) begin
         repeat (L+1) @(posedge clk);
         @(negedge clk);
         check("full_pop_busy", busy, 1);
         check("full_pop_head", rd_data, sb[0]);
         void'(sb.pop_front());
         rd_ready = 1'b1;
         @(negedge clk);
         rd_ready = 1'b0;
         check("full_pop_count", count, D);
         repeat (8) @(negedge clk);
      end else begin
         repeat (10) @(negedge clk);
      end
      ps2c = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic drain();
      int n;
      logic [7:0] exp;
      n = sb.size();
      for (int i = 0; i < n; i++) begin
         exp = sb.pop_front();
         check("drain_valid", rd_valid, 1);
         check("drain_data", rd_data, exp);
         check("drain_count", count, n - i);
         rd_ready = 1'b1;
         @(negedge clk);
      end
      rd_ready = 1'b0;
      check("drain_empty_valid", rd_valid, 0);
      check("drain_empty_count", count, 0);
   endtask

   initial begin
      int base_ovf, base_err, base_busy, first;
      reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b1; rd_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", rd_valid, 0);
      check("rst_data", rd_data, 0);
      check("rst_count", count, 0);
      check("rst_busy", busy, 0);
      check("rst_ticks", {err_tick, overflow_tick, timeout_tick}, 0);
      reset = 1'b0;
      repeat (L+6) @(negedge clk);

      // single byte, latency
      sb.push_back(8'h1C);
      send_frame(8'h1C, 1'b0, 1'b1, 1);
      check("t1_ticks", n_err + n_ovf + n_to, 0);
      drain();

      // multi-byte scan code, in order
      foreach (sb[i]) sb.delete(i);
      send_frame(8'hE0, 1'b0, 1'b1, 0); sb.push_back(8'hE0);
      send_frame(8'hF0, 1'b0, 1'b1, 0); sb.push_back(8'hF0);
      send_frame(8'h1C, 1'b0, 1'b1, 0); sb.push_back(8'h1C);
      check("t2_count", count, 3);
      drain();

      // overflow without a pop
      base_ovf = n_ovf;
      for (int i = 0; i < 9; i++) begin
         send_frame(8'(i), 1'b0, 1'b1, 0);
         if (i < D) sb.push_back(8'(i));
      end
      check("ovf_count", count, D);
      check("ovf_ticks", n_ovf - base_ovf, 1);
      drain();

      // full FIFO with a pop in the CHECK cycle accepts the push
      base_ovf = n_ovf;
      for (int i = 0; i < 8; i++) begin
         send_frame(8'h10 + 8'(i), 1'b0, 1'b1, 0);
         sb.push_back(8'h10 + 8'(i));
      end
      send_frame(8'h18, 1'b0, 1'b1, 2);
      sb.push_back(8'h18);
      check("full_pop_ovf", n_ovf - base_ovf, 0);
      drain();

      // bad parity, bad stop
      base_err = n_err;
      send_frame(8'h1C, 1'b1, 1'b1, 0);
      send_frame(8'h33, 1'b0, 1'b0, 0);
`ifdef PS2_RX_PARITY_CHECK_EN
      check("bad_err_ticks", n_err - base_err, 2);
      check("bad_count", count, 0);
`else
      sb.push_back(8'h1C);
      sb.push_back(8'h33);
      check("bad_err_ticks", n_err - base_err, 0);
      check("bad_count", count, 2);
      drain();
`endif

      // inactivity timeout after 5 bits
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      @(negedge clk); ps2d = 1'b1;
      repeat (5) @(negedge clk);
      ps2c = 1'b0;
      first = 0;
      for (int k = 1; k <= L + TO + 40; k++) begin
         @(posedge clk);
         #1;
         if (k == 10) ps2c = 1'b1;
         if (timeout_tick && first == 0) first = k;
      end
      check("to_latency", first, L + TO);
      check("to_ticks", n_to, 1);
      check("to_busy", busy, 0);
      check("to_count", count, 0);
      send_frame(8'h5A, 1'b0, 1'b1, 0);
      sb.push_back(8'h5A);
      drain();

      // async reset mid-frame with bytes buffered
      for (int i = 0; i < 3; i++) send_frame(8'hA0 + 8'(i), 1'b0, 1'b1, 0);
      check("pre_rst_count", count, 3);
      send_bit(1'b0);
      send_bit(1'b1);
      check("pre_rst_busy", busy, 1);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_valid", rd_valid, 0);
      check("mid_rst_data", rd_data, 0);
      check("mid_rst_count", count, 0);
      check("mid_rst_busy", busy, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (L+6) @(negedge clk);
      send_frame(8'h29, 1'b0, 1'b1, 0);
      check("post_rst_count", count, 1);
      sb.push_back(8'h29);
      drain();

      // start fall while rx_en is low is ignored
      rx_en = 1'b0;
      base_busy = n_busy;
      send_frame(8'h44, 1'b0, 1'b1, 0);
      check("rx_dis_busy", n_busy - base_busy, 0);
      check("rx_dis_count", count, 0);
      rx_en = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
